// File: rtl/sampler_pkg.sv
// Shared types and constants for the sampler capture controller.
// Holds the FSM state encoding, the AXI OKAY code and the burst size helper.
package sampler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Every beat advances the address by one 32-bit word.
  function automatic int unsigned burst_bytes(input int unsigned beats);
    return beats * 4;
  endfunction

endpackage

// File: rtl/sampler_burst_buf.sv
// Single-burst sample buffer: independent write and read pointers, no flow control.
// The controller guarantees it never writes more than DEPTH words before draining them.
module sampler_burst_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: the storage array is deliberately not reset; its contents are only
  // read after being written, so only the pointers need a known state.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so both pointers wrap back to 0 after a full burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sampler_capture_ctrl.sv
// Capture controller: buffers one burst of samples, then writes it out over an
// AXI write channel, repeating for num_bursts bursts at consecutive addresses.
module sampler_capture_ctrl
  import sampler_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_BURST_LEN        = 8,
  parameter int C_MAX_BURSTS_W     = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [C_MAX_BURSTS_W-1:0]     num_bursts,
  input  logic                          s_valid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] s_data,
  output logic                          s_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [7:0]                    M_AXI_AWLEN,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic                          M_AXI_WLAST,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY
);

  localparam int BEAT_W = $clog2(C_BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(C_BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] PENULT_BEAT = BEAT_W'(C_BURST_LEN - 2);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_STEP =
    C_M_AXI_ADDR_WIDTH'(burst_bytes(C_BURST_LEN));

  state_t                          state;
  logic                            armed;
  logic [BEAT_W-1:0]               beat;
  logic [C_MAX_BURSTS_W-1:0]       bursts_left;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic                            awvalid;
  logic                            wvalid;
  logic                            wlast;
  logic                            bready;
  logic                            s_ready_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            err_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   buf_rd_data;

  sampler_burst_buf #(
    .DEPTH (C_BURST_LEN),
    .WIDTH (C_M_AXI_DATA_WIDTH)
  ) u_buf (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (s_valid & s_ready_q),
    .wr_data (s_data),
    .rd_en   (wvalid & M_AXI_WREADY),
    .rd_data (buf_rd_data)
  );

  // NOTE: all state and registered outputs update with non-blocking assignments
  // so every branch sees the pre-edge values, exactly like the flops they become.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= ST_IDLE;
      armed       <= 1'b0;
      beat        <= '0;
      bursts_left <= '0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      wlast       <= 1'b0;
      bready      <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // The first edge after reset only arms the controller; start counts from the second.
      armed  <= 1'b1;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && armed) begin
            awaddr      <= base_addr;
            bursts_left <= (num_bursts == '0) ? C_MAX_BURSTS_W'(1) : num_bursts;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            s_ready_q   <= 1'b1;
            beat        <= '0;
            state       <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (s_valid) begin
            if (beat == LAST_BEAT) begin
              beat      <= '0;
              s_ready_q <= 1'b0;
              awvalid   <= 1'b1;
              state     <= ST_ADDR;
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        ST_ADDR: begin
          if (M_AXI_AWREADY) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (M_AXI_WREADY) begin
            if (wlast) begin
              wvalid <= 1'b0;
              wlast  <= 1'b0;
              bready <= 1'b1;
              beat   <= '0;
              state  <= ST_RESP;
            end else begin
              beat  <= beat + BEAT_W'(1);
              wlast <= (beat == PENULT_BEAT);
            end
          end
        end
        ST_RESP: begin
          if (M_AXI_BVALID) begin
            bready <= 1'b0;
            if (M_AXI_BRESP != RESP_OKAY) err_q <= 1'b1;
            // An error response is recorded but the capture carries on regardless.
            if (bursts_left == C_MAX_BURSTS_W'(1)) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end else begin
              bursts_left <= bursts_left - C_MAX_BURSTS_W'(1);
              awaddr      <= awaddr + ADDR_STEP;
              s_ready_q   <= 1'b1;
              state       <= ST_FILL;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready       = s_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign M_AXI_AWADDR  = awaddr;
  assign M_AXI_AWLEN   = awvalid ? 8'(C_BURST_LEN - 1) : 8'd0;
  assign M_AXI_AWVALID = awvalid;
  assign M_AXI_WDATA   = wvalid ? buf_rd_data : '0;
  assign M_AXI_WLAST   = wlast;
  assign M_AXI_WVALID  = wvalid;
  assign M_AXI_BREADY  = bready;

endmodule

// File: tb/tb_sampler_capture_ctrl.sv
// Self-checking bench for sampler_capture_ctrl: a scoreboard model checked every
// cycle plus directed scenarios with hand-computed expectations.
module tb_sampler_capture_ctrl;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int NBW = 8;

  logic           ACLK = 1'b0;
  logic           ARESETN = 1'b0;
  logic           start = 1'b0;
  logic [AW-1:0]  base_addr = '0;
  logic [NBW-1:0] num_bursts = '0;
  logic           s_valid = 1'b1;
  logic [DW-1:0]  s_data = 32'd1;
  logic           s_ready, busy, done, err;
  logic [AW-1:0]  M_AXI_AWADDR;
  logic [7:0]     M_AXI_AWLEN;
  logic           M_AXI_AWVALID;
  logic           M_AXI_AWREADY = 1'b1;
  logic [DW-1:0]  M_AXI_WDATA;
  logic           M_AXI_WLAST, M_AXI_WVALID;
  logic           M_AXI_WREADY = 1'b1;
  logic [1:0]     M_AXI_BRESP = 2'b00;
  logic           M_AXI_BVALID = 1'b1;
  logic           M_AXI_BREADY;

  sampler_capture_ctrl #(
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .C_BURST_LEN        (BL),
    .C_MAX_BURSTS_W     (NBW)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .start         (start),
    .base_addr     (base_addr),
    .num_bursts    (num_bursts),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWLEN   (M_AXI_AWLEN),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WLAST   (M_AXI_WLAST),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred where none was expected (t=%0t)", name, $time);
  endtask

  // ---------------- scoreboard model ----------------
  logic [AW-1:0] exp_aw[$];
  logic [DW-1:0] exp_w[$];
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  logic          wl_log[$];
  int            done_cnt = 0;
  int            stall_cnt = 0;
  logic          m_busy = 1'b0, m_err = 1'b0, pend_done = 1'b0;
  int            m_left = 0, w_beat = 0, m_nb = 0;
  logic          prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_wlast = 1'b0;
  logic [AW-1:0] prev_awaddr = '0;
  logic [DW-1:0] prev_wdata = '0;

  always @(negedge ACLK) begin
    if (!ARESETN) begin
      exp_aw.delete();
      exp_w.delete();
      m_busy = 1'b0; m_err = 1'b0; pend_done = 1'b0;
      m_left = 0; w_beat = 0;
      prev_aw_stall = 1'b0; prev_w_stall = 1'b0;
    end else begin
      check("busy", busy, m_busy);
      check("done", done, pend_done);
      check("err", err, m_err);
      check("one_active_channel",
            $countones({s_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}), m_busy ? 1 : 0);
      if (done) done_cnt++;
      pend_done = 1'b0;

      if (prev_aw_stall) check("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, prev_awaddr});
      if (prev_w_stall) begin
        stall_cnt++;
        check("w_hold", {M_AXI_WVALID, M_AXI_WLAST, M_AXI_WDATA}, {1'b1, prev_wlast, prev_wdata});
      end

      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_log.push_back(M_AXI_AWADDR);
        if (exp_aw.size() == 0) flag("aw_extra_handshake");
        else check("awaddr", M_AXI_AWADDR, exp_aw.pop_front());
        check("awlen", M_AXI_AWLEN, 8'(BL - 1));
      end
      if (s_valid && s_ready) exp_w.push_back(s_data);
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_log.push_back(M_AXI_WDATA);
        wl_log.push_back(M_AXI_WLAST);
        if (exp_w.size() == 0) flag("w_extra_beat");
        else check("wdata", M_AXI_WDATA, exp_w.pop_front());
        check("wlast", M_AXI_WLAST, w_beat == BL - 1);
        w_beat = (w_beat + 1) % BL;
      end
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        if (M_AXI_BRESP != 2'b00) m_err = 1'b1;
        m_left--;
        if (m_left <= 0) begin
          pend_done = 1'b1;
          m_busy    = 1'b0;
        end
      end
      if (start && !m_busy) begin
        m_nb = (num_bursts == 0) ? 1 : int'(num_bursts);
        for (int i = 0; i < m_nb; i++) exp_aw.push_back(base_addr + AW'(i * BL * 4));
        m_left = m_nb;
        m_busy = 1'b1;
        m_err  = 1'b0;
      end

      prev_aw_stall = M_AXI_AWVALID && !M_AXI_AWREADY;
      prev_awaddr   = M_AXI_AWADDR;
      prev_w_stall  = M_AXI_WVALID && !M_AXI_WREADY;
      prev_wdata    = M_AXI_WDATA;
      prev_wlast    = M_AXI_WLAST;
    end
  end

  // ---------------- stimulus ----------------
  logic toggle_mode = 1'b0;
  int   bad_burst = 0;
  int   resp_idx = 0;

  // One clock: sample handshakes at the falling edge, update inputs 1ns after the rising edge.
  task automatic tick();
    logic hs;
    @(negedge ACLK);
    hs = s_valid && s_ready;
    if (M_AXI_BVALID && M_AXI_BREADY) resp_idx++;
    @(posedge ACLK);
    #1;
    if (hs) s_data = s_data + 1;
    if (toggle_mode) begin
      M_AXI_WREADY  = ~M_AXI_WREADY;
      M_AXI_AWREADY = ~M_AXI_AWREADY;
    end else begin
      M_AXI_WREADY  = 1'b1;
      M_AXI_AWREADY = 1'b1;
    end
    M_AXI_BRESP = (resp_idx + 1 == bad_burst) ? 2'b10 : 2'b00;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input logic [NBW-1:0] nb);
    resp_idx    = 0;
    M_AXI_BRESP = (bad_burst == 1) ? 2'b10 : 2'b00;
    base_addr   = base;
    num_bursts  = nb;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int i = 0; i < 400 && done_cnt == d0; i++) tick();
    check(name, done_cnt != d0, 1'b1);
    repeat (3) tick();
    check({name, "_single_pulse"}, done_cnt - d0, 1);
  endtask

  int aw_mark, w_mark, d0, ones, guard;

  initial begin
    #1;
    check("rst_outputs_zero",
          {s_ready, busy, done, err, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
           M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY}, '0);
    check("rst_wdata_zero", M_AXI_WDATA, '0);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    tick();  // first edge after release

    // 1: base 0, one burst, samples 1..8; start lands on the second edge after reset
    aw_mark = aw_log.size(); w_mark = w_log.size(); d0 = done_cnt;
    s_data = 32'd1;
    pulse_start(32'h0, 8'd1);
    check("t1_busy_after_start", busy, 1'b1);
    wait_done("t1_done", d0);
    check("t1_aw_count", aw_log.size() - aw_mark, 1);
    check("t1_awaddr", aw_log[aw_mark], 32'h0);
    check("t1_beats", w_log.size() - w_mark, 8);
    for (int i = 0; i < 8; i++) check("t1_wdata", w_log[w_mark + i], 32'(i + 1));
    check("t1_wlast_b7", wl_log[w_mark + 6], 1'b0);
    check("t1_wlast_b8", wl_log[w_mark + 7], 1'b1);
    check("t1_err", err, 1'b0);

    // 2: two bursts from 0x100, samples 1..16
    aw_mark = aw_log.size(); w_mark = w_log.size(); d0 = done_cnt;
    s_data = 32'd1;
    pulse_start(32'h100, 8'd2);
    wait_done("t2_done", d0);
    check("t2_aw_count", aw_log.size() - aw_mark, 2);
    check("t2_awaddr0", aw_log[aw_mark], 32'h100);
    check("t2_awaddr1", aw_log[aw_mark + 1], 32'h120);
    for (int i = 8; i < 16; i++) check("t2_wdata", w_log[w_mark + i], 32'(i + 1));

    // 3: WREADY and AWREADY toggling every cycle
    aw_mark = aw_log.size(); w_mark = w_log.size(); d0 = done_cnt;
    s_data = 32'h30;
    toggle_mode = 1'b1;
    pulse_start(32'h200, 8'd1);
    wait_done("t3_done", d0);
    toggle_mode = 1'b0;
    check("t3_beats", w_log.size() - w_mark, 8);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(wl_log[w_mark + i]);
    check("t3_wlast_count", ones, 1);
    check("t3_wlast_last", wl_log[w_mark + 7], 1'b1);
    check("t3_wdata_last", w_log[w_mark + 7], 32'h37);
    check("t3_stalls_seen", stall_cnt > 0, 1'b1);

    // 4: error response on burst 1 of 2
    aw_mark = aw_log.size(); d0 = done_cnt;
    bad_burst = 1;
    pulse_start(32'h400, 8'd2);
    wait_done("t4_done", d0);
    bad_burst = 0;
    check("t4_err_sticky", err, 1'b1);
    check("t4_aw_count", aw_log.size() - aw_mark, 2);
    check("t4_awaddr1", aw_log[aw_mark + 1], 32'h420);

    // 5: start during DATA is ignored; err from the previous run clears on accepted start
    aw_mark = aw_log.size(); d0 = done_cnt;
    pulse_start(32'h600, 8'd1);
    check("t5_err_cleared", err, 1'b0);
    guard = 0;
    while (!M_AXI_WVALID && guard < 50) begin tick(); guard++; end
    check("t5_reached_data", M_AXI_WVALID, 1'b1);
    base_addr = 32'hA00; start = 1'b1; tick(); start = 1'b0;
    wait_done("t5_done", d0);
    repeat (20) tick();
    check("t5_aw_count", aw_log.size() - aw_mark, 1);
    check("t5_awaddr", aw_log[aw_mark], 32'h600);
    check("t5_idle", busy, 1'b0);

    // 6: num_bursts=0 means one burst; address wraps at 2^32 on a two-burst run
    aw_mark = aw_log.size(); d0 = done_cnt;
    pulse_start(32'h7E0, 8'd0);
    wait_done("t6a_done", d0);
    check("t6a_aw_count", aw_log.size() - aw_mark, 1);
    aw_mark = aw_log.size(); d0 = done_cnt;
    pulse_start(32'hFFFF_FFE0, 8'd2);
    wait_done("t6b_done", d0);
    check("t6b_awaddr_wrap", aw_log[aw_mark + 1], 32'h0);

    // 7: reset asserted while beat 4 of DATA is presented
    w_mark = w_log.size();
    s_data = 32'h90;
    pulse_start(32'h800, 8'd1);
    guard = 0;
    while (w_log.size() - w_mark < 3 && guard < 60) begin tick(); guard++; end
    check("t7_three_beats", w_log.size() - w_mark, 3);
    check("t7_beat4_presented", M_AXI_WVALID, 1'b1);
    #2 ARESETN = 1'b0;
    #1;
    check("t7_wvalid_low", M_AXI_WVALID, 1'b0);
    check("t7_busy_low", busy, 1'b0);
    check("t7_outputs_zero",
          {s_ready, done, err, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID,
           M_AXI_WLAST, M_AXI_BREADY, M_AXI_WDATA}, '0);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    tick();
    aw_mark = aw_log.size(); w_mark = w_log.size(); d0 = done_cnt;
    s_data = 32'h50;
    pulse_start(32'h60, 8'd1);
    wait_done("t7_done", d0);
    check("t7_awaddr", aw_log[aw_mark], 32'h60);
    check("t7_beats", w_log.size() - w_mark, 8);
    check("t7_wdata_first", w_log[w_mark], 32'h50);
    check("t7_wdata_last", w_log[w_mark + 7], 32'h57);
    check("t7_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200 us");
    $fatal(1, "watchdog expired");
  end

endmodule
